bk_sdram_bridge: RTL and testbench

//  Converts the async-SRAM-style strobes from the BK0010 top level (SRAM_ADDR/CE_N/WE_N/OE_N/UB_N/LB_N,

---
 rtl/bk_sdram_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_bk_sdram_bridge.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_sdram_bridge.sv
// Bridge from the BK0010 async-SRAM strobes and the video fetch port to the
// shared SDRAM controller's request/ack interface; video has priority over the CPU.
module bk_sdram_bridge #(
  parameter int unsigned      SD_AW    = 22,
  parameter logic [SD_AW-1:0] CPU_BASE = 22'h0,
  parameter logic [SD_AW-1:0] VGA_BASE = 22'h2000,
  parameter logic [7:0]       TMO      = 8'd255
) (
  input  logic             clk25,
  input  logic             RST_IN,
  input  logic [17:0]      sram_addr,
  input  logic [15:0]      sram_dataw,
  input  logic             sram_ce_n,
  input  logic             sram_we_n,
  input  logic             sram_oe_n,
  input  logic             sram_ub_n,
  input  logic             sram_lb_n,
  output logic [15:0]      sram_datar,
  output logic             membusy,
  input  logic [12:0]      vga_addr,
  input  logic             vga_req,
  output logic [15:0]      vdata,
  output logic             vdata_vld,
  output logic             sd_req,
  output logic             sd_we,
  output logic [SD_AW-1:0] sd_addr,
  output logic [15:0]      sd_wdata,
  output logic [1:0]       sd_be,
  input  logic             sd_ack,
  input  logic [15:0]      sd_rdata,
  input  logic             sd_rvalid,
  output logic             tmo_err
);

  typedef enum logic [1:0] {IDLE, VRD, CRD, CWR} state_t;

  localparam logic [7:0] TMO_LAST = TMO - 8'd1;

  state_t             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic               last_act_q, last_act_d;
  logic [17:0]        last_addr_q, last_addr_d;
  logic               last_we_q, last_we_d;
  logic               cpu_busy_q, cpu_busy_d;
  logic               vga_pend_q, vga_pend_d;
  logic               vga_again_q, vga_again_d;
  logic [12:0]        vga_addr_q, vga_addr_d;
  logic               sd_req_q, sd_req_d;
  logic               sd_we_q, sd_we_d;
  logic [SD_AW-1:0]   sd_addr_q, sd_addr_d;
  logic [15:0]        sd_wdata_q, sd_wdata_d;
  logic [1:0]         sd_be_q, sd_be_d;
  logic [15:0]        sram_datar_q, sram_datar_d;
  logic [15:0]        vdata_q, vdata_d;
  logic               vdata_vld_q, vdata_vld_d;
  logic               tmo_err_q, tmo_err_d;

  logic               cpu_act, new_acc, vga_any, tmo_hit;
  logic               cpu_done, vga_done, abort;
  logic [1:0]         cpu_be;
  logic [12:0]        vga_cur;
  logic [SD_AW-1:0]   cpu_sum, vga_sum;

  always_comb begin
    cpu_act = ~sram_ce_n & (~sram_oe_n | ~sram_we_n);
    new_acc = cpu_act & (~last_act_q | (sram_addr != last_addr_q) | (sram_we_n != last_we_q));
    cpu_be  = {~sram_ub_n, ~sram_lb_n};
    vga_any = vga_pend_q | vga_req;
    vga_cur = vga_req ? vga_addr : vga_addr_q;
    cpu_sum = CPU_BASE + SD_AW'(sram_addr);
    vga_sum = VGA_BASE + SD_AW'(vga_cur);
    tmo_hit = (timer_q == TMO_LAST);
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 8'd1;
    last_act_d   = last_act_q;
    last_addr_d  = last_addr_q;
    last_we_d    = last_we_q;
    cpu_busy_d   = cpu_busy_q;
    vga_pend_d   = vga_pend_q;
    vga_addr_d   = vga_addr_q;
    sd_req_d     = sd_req_q;
    sd_we_d      = sd_we_q;
    sd_addr_d    = sd_addr_q;
    sd_wdata_d   = sd_wdata_q;
    sd_be_d      = sd_be_q;
    sram_datar_d = sram_datar_q;
    vdata_d      = vdata_q;
    vdata_vld_d  = 1'b0;
    cpu_done     = 1'b0;
    vga_done     = 1'b0;
    abort        = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (vga_any) begin
          state_d   = VRD;
          sd_req_d  = 1'b1;
          sd_we_d   = 1'b0;
          sd_addr_d = vga_sum;
          sd_be_d   = 2'b11;
        end else if (new_acc && !sram_we_n && cpu_be == 2'b00) begin
          cpu_done = 1'b1;
        end else if (new_acc) begin
          state_d    = sram_we_n ? CRD : CWR;
          sd_req_d   = 1'b1;
          sd_we_d    = ~sram_we_n;
          sd_addr_d  = cpu_sum;
          sd_wdata_d = sram_dataw;
          sd_be_d    = sram_we_n ? 2'b11 : cpu_be;
          cpu_busy_d = 1'b1;
        end
      end
      VRD: begin
        if (sd_rvalid) begin
          vdata_d     = sd_rdata;
          vdata_vld_d = 1'b1;
          vga_done    = 1'b1;
        end else if (tmo_hit) begin
          vdata_d     = '1;
          vdata_vld_d = 1'b1;
          vga_done    = 1'b1;
          abort       = 1'b1;
        end
      end
      CRD: begin
        if (sd_rvalid) begin
          sram_datar_d = sd_rdata;
          cpu_done     = 1'b1;
        end else if (tmo_hit) begin
          sram_datar_d = '1;
          cpu_done     = 1'b1;
          abort        = 1'b1;
        end
      end
      CWR: begin
        if (sd_ack) begin
          cpu_done = 1'b1;
        end else if (tmo_hit) begin
          cpu_done = 1'b1;
          abort    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A read may see its ack well before rvalid: request drops, state waits on.
    if (state_q != IDLE) begin
      if (sd_ack) sd_req_d = 1'b0;
      if (cpu_done || vga_done) begin
        state_d  = IDLE;
        sd_req_d = 1'b0;
      end
    end

    tmo_err_d = tmo_err_q | abort;

    if (cpu_done) begin
      cpu_busy_d  = 1'b0;
      last_act_d  = 1'b1;
      last_addr_d = sram_addr;
      last_we_d   = sram_we_n;
    end else if (!cpu_act) begin
      last_act_d = 1'b0;
    end

    // A fetch requested while VRD is in flight must survive that VRD's completion.
    vga_again_d = (state_q == VRD) & (vga_again_q | vga_req);
    if (vga_done) vga_pend_d = vga_again_q;
    if (vga_req) begin
      vga_pend_d = 1'b1;
      vga_addr_d = vga_addr;
    end
  end

  always_ff @(posedge clk25 or posedge RST_IN) begin
    if (RST_IN) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      last_act_q   <= 1'b0;
      last_addr_q  <= '0;
      last_we_q    <= 1'b0;
      cpu_busy_q   <= 1'b0;
      vga_pend_q   <= 1'b0;
      vga_again_q  <= 1'b0;
      vga_addr_q   <= '0;
      sd_req_q     <= 1'b0;
      sd_we_q      <= 1'b0;
      sd_addr_q    <= '0;
      sd_wdata_q   <= '0;
      sd_be_q      <= '0;
      sram_datar_q <= '0;
      vdata_q      <= '0;
      vdata_vld_q  <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_act_q   <= last_act_d;
      last_addr_q  <= last_addr_d;
      last_we_q    <= last_we_d;
      cpu_busy_q   <= cpu_busy_d;
      vga_pend_q   <= vga_pend_d;
      vga_again_q  <= vga_again_d;
      vga_addr_q   <= vga_addr_d;
      sd_req_q     <= sd_req_d;
      sd_we_q      <= sd_we_d;
      sd_addr_q    <= sd_addr_d;
      sd_wdata_q   <= sd_wdata_d;
      sd_be_q      <= sd_be_d;
      sram_datar_q <= sram_datar_d;
      vdata_q      <= vdata_d;
      vdata_vld_q  <= vdata_vld_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  // membusy is combinational, so it is masked while reset is held.
  assign membusy    = ~RST_IN & (new_acc | cpu_busy_q);
  assign sram_datar = sram_datar_q;
  assign vdata      = vdata_q;
  assign vdata_vld  = vdata_vld_q;
  assign sd_req     = sd_req_q;
  assign sd_we      = sd_we_q;
  assign sd_addr    = sd_addr_q;
  assign sd_wdata   = sd_wdata_q;
  assign sd_be      = sd_be_q;
  assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_bk_sdram_bridge.sv
// Scoreboard bench for bk_sdram_bridge: stimulus pushes expected SDRAM requests
// and read data; an SDRAM responder and a monitor run alongside.
module tb_bk_sdram_bridge;

  localparam logic [21:0] CBASE = 22'h0;
  localparam logic [21:0] VBASE = 22'h2000;
  localparam int          LIMIT = 600;

  logic        clk25, RST_IN;
  logic [17:0] sram_addr;
  logic [15:0] sram_dataw, sram_datar, vdata, sd_wdata, sd_rdata;
  logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic        membusy, vga_req, vdata_vld, sd_req, sd_we, sd_ack, sd_rvalid, tmo_err;
  logic [12:0] vga_addr;
  logic [21:0] sd_addr;
  logic [1:0]  sd_be;

  bk_sdram_bridge #(
    .SD_AW(22), .CPU_BASE(22'h0), .VGA_BASE(22'h2000), .TMO(8'd255)
  ) dut (
    .clk25(clk25), .RST_IN(RST_IN),
    .sram_addr(sram_addr), .sram_dataw(sram_dataw), .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .sram_datar(sram_datar), .membusy(membusy),
    .vga_addr(vga_addr), .vga_req(vga_req), .vdata(vdata), .vdata_vld(vdata_vld),
    .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_be(sd_be), .sd_ack(sd_ack), .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid),
    .tmo_err(tmo_err)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } req_t;

  req_t        exp_req[$];
  logic [15:0] exp_vdata[$];
  logic [15:0] exp_datar[$];
  int          checks, failures;
  int          resp_mode;   // 0 random, 1 ack+rvalid with A5A5, 2 rvalid 5 after ack, 3 silent

  function automatic logic [15:0] mem_f(input logic [21:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {10'd0, a[21:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // SDRAM controller model
  initial begin : responder
    logic        rd;
    logic [21:0] a;
    logic [15:0] d;
    int          lat, dly;
    sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0;
    forever begin
      @(negedge clk25);
      if (sd_req && resp_mode != 3) begin
        rd  = !sd_we;
        a   = sd_addr;
        d   = (resp_mode == 1) ? 16'hA5A5 : mem_f(a);
        lat = (resp_mode == 0) ? $urandom_range(0, 3) : 0;
        dly = (resp_mode == 1) ? 0 : (resp_mode == 2) ? 5 :
              ($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 6));
        repeat (lat) @(negedge clk25);
        sd_ack = 1'b1;
        if (rd && dly == 0) begin sd_rvalid = 1'b1; sd_rdata = d; end
        @(negedge clk25);
        sd_ack = 1'b0; sd_rvalid = 1'b0;
        if (rd && dly > 0) begin
          repeat (dly - 1) @(negedge clk25);
          sd_rvalid = 1'b1; sd_rdata = d;
          @(negedge clk25);
          sd_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic prev_req, prev_busy, stable;
    req_t cur, now, e;
    prev_req = 1'b0; prev_busy = 1'b0; stable = 1'b1; cur = '0;
    forever begin
      @(posedge clk25); #1;
      if (RST_IN) begin
        prev_req = 1'b0; prev_busy = 1'b0;
      end else begin
        now = '{we: sd_we, addr: sd_addr, wdata: sd_wdata, be: sd_be};
        if (sd_req && !prev_req) begin
          cur = now; stable = 1'b1;
          if (exp_req.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_req actual=%0h required=none", now);
          end else begin
            e = exp_req.pop_front();
            check("req_we", sd_we, e.we);
            check("req_addr", sd_addr, e.addr);
            check("req_be", sd_be, e.be);
            if (e.we) check("req_wdata", sd_wdata, e.wdata);
          end
        end else if (sd_req && now != cur) begin
          stable = 1'b0;
        end
        if (!sd_req && prev_req) check("req_stable", stable, 1);
        if (vdata_vld) begin
          if (exp_vdata.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_vdata actual=%0h required=none", vdata);
          end else check("vdata", vdata, exp_vdata.pop_front());
        end
        if (prev_busy && !membusy && !sram_ce_n && !sram_oe_n && sram_we_n) begin
          if (exp_datar.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_read actual=%0h required=none", sram_datar);
          end else check("datar", sram_datar, exp_datar.pop_front());
        end
        prev_req  = sd_req;
        prev_busy = membusy;
      end
    end
  end

  // Called at a falling edge; returns the number of falling edges (including the
  // first) at which membusy was seen high.
  task automatic access(input bit do_cpu, input bit wr, input logic [17:0] a,
                        input logic [15:0] d, input logic ub_n, input logic lb_n,
                        input bit do_vga, input logic [12:0] va,
                        input logic [15:0] rd_exp, output int busy_n);
    logic [1:0] be;
    int g;
    be = {~ub_n, ~lb_n};
    if (do_vga) begin
      exp_req.push_back('{we: 1'b0, addr: 22'(VBASE + {9'd0, va}), wdata: 16'h0, be: 2'b11});
      exp_vdata.push_back(mem_f(22'(VBASE + {9'd0, va})));
      vga_addr = va; vga_req = 1'b1;
    end
    if (do_cpu) begin
      if (!wr) begin
        exp_req.push_back('{we: 1'b0, addr: 22'(CBASE + {4'd0, a}), wdata: 16'h0, be: 2'b11});
        exp_datar.push_back(rd_exp);
      end else if (be != 2'b00) begin
        exp_req.push_back('{we: 1'b1, addr: 22'(CBASE + {4'd0, a}), wdata: d, be: be});
      end
      sram_addr = a; sram_dataw = d; sram_ub_n = ub_n; sram_lb_n = lb_n;
      sram_ce_n = 1'b0; sram_we_n = ~wr; sram_oe_n = wr;
    end
    busy_n = 0;
    #1;
    while (membusy && busy_n < LIMIT) begin
      busy_n++;
      @(negedge clk25);
      vga_req = 1'b0;
    end
    if (vga_req) begin @(negedge clk25); vga_req = 1'b0; end
    if (busy_n >= LIMIT) begin
      checks++; failures++;
      $display("FAIL membusy_stuck actual=%0d required=<%0d", busy_n, LIMIT);
    end
    sram_ce_n = 1'b1; sram_we_n = 1'b1; sram_oe_n = 1'b1;
    g = 0;
    while (exp_vdata.size() != 0 && g < 200) begin @(negedge clk25); g++; end
    if (g >= 200) begin
      checks++; failures++;
      $display("FAIL vdata_missing actual=%0d required=0", exp_vdata.size());
    end
    repeat ($urandom_range(1, 3)) @(negedge clk25);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int busy, kind;
    logic [17:0] a;
    logic [15:0] d;
    logic [12:0] va;
    logic        ub, lb;
    checks = 0; failures = 0; resp_mode = 0;
    RST_IN = 1'b1;
    sram_addr = '0; sram_dataw = '0; sram_ce_n = 1'b1; sram_we_n = 1'b1;
    sram_oe_n = 1'b1; sram_ub_n = 1'b1; sram_lb_n = 1'b1;
    vga_addr = '0; vga_req = 1'b0;
    repeat (3) @(negedge clk25);
    check("rst_sd_req", sd_req, 0);
    check("rst_sd_we", sd_we, 0);
    check("rst_sd_addr", sd_addr, 0);
    check("rst_sd_wdata", sd_wdata, 0);
    check("rst_sd_be", sd_be, 0);
    check("rst_datar", sram_datar, 0);
    check("rst_vdata", vdata, 0);
    check("rst_vdata_vld", vdata_vld, 0);
    check("rst_membusy", membusy, 0);
    check("rst_tmo_err", tmo_err, 0);
    RST_IN = 1'b0;
    repeat (2) @(negedge clk25);

    // read, ack and rvalid together
    resp_mode = 1;
    access(1, 0, 18'h00100, 16'h0, 1'b1, 1'b1, 0, 13'h0, 16'hA5A5, busy);
    check("busy_same_cycle_rd", busy, 2);
    resp_mode = 0;

    // byte write, high byte only
    access(1, 1, 18'h00200, 16'h1234, 1'b0, 1'b1, 0, 13'h0, 16'h0, busy);
    check("one_write_req", exp_req.size(), 0);

    // video and CPU read presented together
    access(1, 0, 18'h00300, 16'h0, 1'b0, 1'b0, 1, 13'h0010, mem_f(22'h300), busy);

    // address extremes
    access(1, 0, 18'h3FFFF, 16'h0, 1'b1, 1'b0, 1, 13'h1FFF, mem_f(22'h3FFFF), busy);

    // write with no byte lanes
    access(1, 1, 18'h00400, 16'hBEEF, 1'b1, 1'b1, 0, 13'h0, 16'h0, busy);
    check("busy_be00", busy, 1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a  = 18'($urandom);
      d  = 16'($urandom);
      va = 13'($urandom);
      ub = 1'($urandom);
      lb = 1'($urandom);
      case (kind)
        0: access(1, 0, a, d, ub, lb, 0, va, mem_f(22'(CBASE + {4'd0, a})), busy);
        1: begin
          access(1, 1, a, d, ub, lb, 0, va, 16'h0, busy);
          if (ub && lb) check("busy_be00_rand", busy, 1);
        end
        2: access(0, 0, a, d, ub, lb, 1, va, 16'h0, busy);
        default: access(1, 0, a, d, ub, lb, 1, va, mem_f(22'(CBASE + {4'd0, a})), busy);
      endcase
    end

    // rvalid five cycles after ack
    resp_mode = 2;
    access(1, 0, 18'h01234, 16'h0, 1'b1, 1'b1, 0, 13'h0, mem_f(22'h1234), busy);
    check("busy_late_rvalid", busy, 7);
    resp_mode = 0;

    // controller never answers a read
    check("tmo_err_before", tmo_err, 0);
    resp_mode = 3;
    access(1, 0, 18'h02000, 16'h0, 1'b1, 1'b1, 0, 13'h0, 16'hFFFF, busy);
    check("busy_timeout", busy, 256);
    check("tmo_sd_req", sd_req, 0);
    check("tmo_err_set", tmo_err, 1);
    resp_mode = 0;
    access(1, 0, 18'h02001, 16'h0, 1'b1, 1'b1, 0, 13'h0, mem_f(22'h2001), busy);
    check("tmo_err_sticky", tmo_err, 1);

    // reset while a write is stuck in flight
    resp_mode = 3;
    exp_req.push_back('{we: 1'b1, addr: 22'h00500, wdata: 16'h5A5A, be: 2'b11});
    sram_addr = 18'h00500; sram_dataw = 16'h5A5A; sram_ub_n = 1'b0; sram_lb_n = 1'b0;
    sram_ce_n = 1'b0; sram_we_n = 1'b0; sram_oe_n = 1'b1;
    repeat (4) @(negedge clk25);
    check("cwr_sd_req", sd_req, 1);
    #2 RST_IN = 1'b1;
    #1;
    check("rst_mid_sd_req", sd_req, 0);
    check("rst_mid_membusy", membusy, 0);
    check("rst_mid_tmo_err", tmo_err, 0);
    resp_mode = 0;
    exp_req.push_back('{we: 1'b1, addr: 22'h00500, wdata: 16'h5A5A, be: 2'b11});
    @(negedge clk25);
    RST_IN = 1'b0;
    busy = 0;
    #1;
    while (membusy && busy < LIMIT) begin busy++; @(negedge clk25); end
    check("restart_done", (busy > 0 && busy < LIMIT) ? 1 : 0, 1);
    sram_ce_n = 1'b1; sram_we_n = 1'b1;
    repeat (2) @(negedge clk25);

    for (int i = 0; i < 6; i++) begin
      a = 18'($urandom);
      access(1, 0, a, 16'h0, 1'b1, 1'b1, 1, 13'($urandom), mem_f(22'(CBASE + {4'd0, a})), busy);
    end

    repeat (4) @(negedge clk25);
    check("left_req", exp_req.size(), 0);
    check("left_vdata", exp_vdata.size(), 0);
    check("left_datar", exp_datar.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
